// File: rtl/mux_scan.sv
// mux_scan: registered N-to-1 channel multiplexer with a manual select mode and
// an automatic round-robin scan mode that dwells DWELL cycles on each channel.
//
// Ports:
//   clk    in   1      clock, all state updates on rising edge
//   rst_n  in   1      asynchronous active-low reset
//   din    in   N*W    flattened channel data, channel k at [k*W +: W]
//   sel    in   SELW   channel index used in manual mode
//   mode   in   1      0 = manual select, 1 = round-robin scan
//   en     in   1      advance enable; low holds every register
//   s      out  W      registered selected data
//   ch     out  SELW   channel index currently presented on s
//   valid  out  1      s holds data from a legal channel
//   wrap   out  1      one-cycle pulse when scan wraps from N-1 to 0
//
// State   | meaning
// MANUAL  | output follows sel every enabled cycle
// SCAN    | output steps through channels, DWELL cycles each
module mux_scan #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    din,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      s,
    output logic [SELW-1:0]   ch,
    output logic              valid,
    output logic              wrap
);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST    = SELW'(N - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [W-1:0]      s_q, s_d;
    logic [SELW-1:0]   ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;

    // Out-of-range indices select nothing, so the result is zero for them.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                          input logic [SELW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) r = d[k*W +: W];
        end
        return r;
    endfunction

    function automatic logic legal(input logic [SELW-1:0] idx);
        return (int'(idx) < N);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (en) begin
            if (!mode) begin
                // Manual takes effect on the same edge, even when leaving SCAN.
                state_d = MANUAL;
                cnt_d   = '0;
                ch_d    = sel;
                if (legal(sel)) begin
                    s_d     = pick(din, sel);
                    valid_d = 1'b1;
                end else begin
                    s_d     = '0;
                    valid_d = 1'b0;
                end
            end else begin
                state_d = SCAN;
                valid_d = 1'b1;
                if (state_q == MANUAL) begin
                    // Entry: continue from the current channel if it is real.
                    cnt_d = '0;
                    ch_d  = legal(ch_q) ? ch_q : '0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        ch_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ch_d = ch_q + SELW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                s_d = pick(din, ch_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            s_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign s     = s_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Testbench for mux_scan: directed vectors with a scoreboard queue.
// Main instance: W=8 N=4 SELW=2 DWELL=3. Side instance: N=3, manual only.
module tb_mux_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        en;
    logic [7:0]  s;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;

    logic [1:0]  sel3;
    logic [7:0]  s3;
    logic [1:0]  ch3;
    logic        valid3;
    logic        wrap3;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [31:0] D = 32'h44332211;

    typedef struct {
        logic [7:0] s;
        logic [1:0] ch;
        logic       v;
        logic       w;
        bit         c3;
        logic [7:0] s3;
        logic [1:0] ch3;
        logic       v3;
    } exp_t;

    exp_t q[$];

    mux_scan #(.W(8), .N(4), .SELW(2), .DWELL(3)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en),
        .s(s), .ch(ch), .valid(valid), .wrap(wrap)
    );

    mux_scan #(.W(8), .N(3), .SELW(2), .DWELL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .din(din[23:0]), .sel(sel3), .mode(1'b0), .en(en),
        .s(s3), .ch(ch3), .valid(valid3), .wrap(wrap3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drives one cycle of stimulus ahead of the next rising edge and queues
    // the outputs that edge must produce.
    task automatic step(input logic m, input logic [1:0] sl, input logic e,
                        input logic [31:0] dn, input logic [7:0] es,
                        input logic [1:0] ech, input logic ev, input logic ew,
                        input bit c3 = 0, input logic [1:0] sl3 = 2'd1,
                        input logic [7:0] es3 = 8'h00, input logic [1:0] ech3 = 2'd0,
                        input logic ev3 = 1'b0);
        exp_t x;
        @(negedge clk);
        mode = m;
        sel  = sl;
        en   = e;
        din  = dn;
        sel3 = sl3;
        x.s = es; x.ch = ech; x.v = ev; x.w = ew;
        x.c3 = c3; x.s3 = es3; x.ch3 = ech3; x.v3 = ev3;
        q.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s"}, int'(s), 0);
        check({tag, "_ch"}, int'(ch), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_wrap"}, int'(wrap), 0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every edge that has a queued expectation is compared.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("s", int'(s), int'(x.s));
                check("ch", int'(ch), int'(x.ch));
                check("valid", int'(valid), int'(x.v));
                check("wrap", int'(wrap), int'(x.w));
                if (x.c3) begin
                    check("n3_s", int'(s3), int'(x.s3));
                    check("n3_ch", int'(ch3), int'(x.ch3));
                    check("n3_valid", int'(valid3), int'(x.v3));
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 2'd0;
        sel3  = 2'd1;
        din   = D;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Manual select of all four channels; side instance sees an illegal sel.
        step(0, 2'd0, 1, D, 8'h11, 2'd0, 1, 0, 1, 2'd3, 8'h00, 2'd3, 0);
        step(0, 2'd1, 1, D, 8'h22, 2'd1, 1, 0, 1, 2'd1, 8'h22, 2'd1, 1);
        step(0, 2'd2, 1, D, 8'h33, 2'd2, 1, 0);
        step(0, 2'd3, 1, D, 8'h44, 2'd3, 1, 0);

        // Scan from reset, including a din change mid-dwell.
        mid_reset("rst2");
        step(1, 2'd0, 1, D,            8'h11, 2'd0, 1, 0);
        step(1, 2'd0, 1, 32'h4433225A, 8'h5A, 2'd0, 1, 0);
        step(1, 2'd0, 1, D,            8'h11, 2'd0, 1, 0);
        step(1, 2'd0, 1, D, 8'h22, 2'd1, 1, 0);
        step(1, 2'd0, 1, D, 8'h22, 2'd1, 1, 0);
        step(1, 2'd0, 1, D, 8'h22, 2'd1, 1, 0);
        step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h44, 2'd3, 1, 0);
        step(1, 2'd0, 1, D, 8'h44, 2'd3, 1, 0);
        step(1, 2'd0, 1, D, 8'h44, 2'd3, 1, 0);
        step(1, 2'd0, 1, D, 8'h11, 2'd0, 1, 1);

        // Freeze mid-dwell: outputs hold even though din moves, then resume.
        step(1, 2'd0, 1, D, 8'h11, 2'd0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 2'd0, 0, 32'h443322EE, 8'h11, 2'd0, 1, 0);
        step(1, 2'd0, 1, 32'h443322EE, 8'hEE, 2'd0, 1, 0);
        step(1, 2'd0, 1, 32'h443322EE, 8'h22, 2'd1, 1, 0);

        // Manual ch=2, scan from there, then back to manual.
        step(0, 2'd2, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        step(1, 2'd0, 1, D, 8'h44, 2'd3, 1, 0);
        step(0, 2'd1, 1, D, 8'h22, 2'd1, 1, 0);

        // Scan up to the last dwell cycle of ch=3, then reset before the wrap.
        for (int i = 0; i < 3; i++) step(1, 2'd0, 1, D, 8'h22, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 2'd0, 1, D, 8'h33, 2'd2, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 2'd0, 1, D, 8'h44, 2'd3, 1, 0);
        mid_reset("rst3");
        step(1, 2'd0, 1, D, 8'h11, 2'd0, 1, 0);
        step(1, 2'd0, 1, D, 8'h11, 2'd0, 1, 0);
        step(1, 2'd0, 1, D, 8'h11, 2'd0, 1, 0);
        step(1, 2'd0, 1, D, 8'h22, 2'd1, 1, 0);
        step(1, 2'd0, 0, D, 8'h22, 2'd1, 1, 0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
